// File: rtl/apb_master.sv
// apb_master: bridges one CPU load/store at a time onto a four-slave APB bus,
// with address decode, wait-state handling and a wait-state timeout.
module apb_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    // CPU side
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    // APB side
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned NS = 4;
    localparam logic [17:0] SLAVE_BASE = 18'h04000;   // addr[31:14] of 0x1000_0000..0x1000_3FFF
    localparam logic [DW-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait;
    logic [1:0]      r_slave;
    logic            r_mapped;
    logic [NS-1:0]   r_psel;
    logic            r_penable;
    logic            r_pwrite;
    logic [AW-1:0]   r_paddr;
    logic [DW-1:0]   r_pwdata;

    logic            w_req_mapped;
    logic [1:0]      w_req_slave;
    logic            w_sel_ready;
    logic [DW-1:0]   w_sel_rdata;
    logic            w_timeout;

    assign w_req_mapped = (addr[31:14] == SLAVE_BASE);
    assign w_req_slave  = addr[13:12];
    assign w_timeout    = (r_wait == CW'(TIMEOUT));

    // Select the latched slave's ready and read data; others are ignored
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        case (r_slave)
            2'd0: begin w_sel_ready = PREADY0; w_sel_rdata = PRDATA0; end
            2'd1: begin w_sel_ready = PREADY1; w_sel_rdata = PRDATA1; end
            2'd2: begin w_sel_ready = PREADY2; w_sel_rdata = PRDATA2; end
            default: begin w_sel_ready = PREADY3; w_sel_rdata = PRDATA3; end
        endcase
    end

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; ACCESS ends on slave ready, unmapped address or timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (transfer) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (!r_mapped || w_sel_ready || w_timeout) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // CPU completion outputs, combinational from state and selected slave
    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        rdata = '0;
        if (r_state == S_ACCESS) begin
            if (!r_mapped) begin
                ready = 1'b1;
                err   = 1'b1;
            end else if (w_sel_ready) begin
                ready = 1'b1;
                rdata = w_sel_rdata;
            end else if (w_timeout) begin
                ready = 1'b1;
                err   = 1'b1;
                rdata = TIMEOUT_DATA;
            end
        end
    end

    // Registered APB outputs, request latch and wait-state counter
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_slave   <= '0;
            r_mapped  <= 1'b0;
            r_wait    <= '0;
        end else begin
            r_penable <= (w_next == S_ACCESS);
            if (r_state == S_IDLE && transfer) begin
                r_paddr  <= addr;
                r_pwdata <= wdata;
                r_pwrite <= write;
                r_slave  <= w_req_slave;
                r_mapped <= w_req_mapped;
                r_psel   <= w_req_mapped ? NS'(4'b0001 << w_req_slave) : '0;
            end else if (w_next == S_IDLE) begin
                r_psel <= '0;
            end
            if (r_state != S_ACCESS) begin
                r_wait <= '0;
            end else if (w_next == S_ACCESS) begin
                r_wait <= r_wait + CW'(1);
            end
        end
    end

    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PWRITE  = r_pwrite;
    assign PENABLE = r_penable;
    assign PSEL0   = r_psel[0];
    assign PSEL1   = r_psel[1];
    assign PSEL2   = r_psel[2];
    assign PSEL3   = r_psel[3];

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: slave models plus a per-cycle expectation queue
// built from the transaction rules, drained by one compare process.
module tb_apb_master;

    localparam int unsigned TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        transfer = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready, err;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    apb_master #(.TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    always #5 PCLK = ~PCLK;

    // Slave 0: RAM with registered PREADY (one wait state)
    logic [31:0] ram [0:1023];
    logic        rdy0;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) rdy0 <= 1'b0;
        else        rdy0 <= PSEL0 & PENABLE;
    end
    always @(posedge PCLK) begin
        if (PSEL0 && PENABLE && PWRITE && rdy0) ram[PADDR[11:2]] <= PWDATA;
    end
    assign PREADY0 = rdy0;
    assign PRDATA0 = ram[PADDR[11:2]];

    // Slaves 1..3: zero-wait, address-dependent read patterns; slave 3 can hang
    logic s3_rdy = 1'b1;
    assign PREADY1 = 1'b1;
    assign PREADY2 = 1'b1;
    assign PREADY3 = s3_rdy;
    assign PRDATA1 = {16'h6010, 4'h0, PADDR[11:0]};
    assign PRDATA2 = {16'hF2D0, 4'h0, PADDR[11:0]};
    assign PRDATA3 = 32'h5BA3_0000 ^ PADDR;

    typedef struct {
        logic [3:0]  psel;
        logic        penable;
        logic        chk_bus;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
        logic        ready;
        logic        err;
        logic        chk_rdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] model_mem [int unsigned];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          n_ready = 0;
    int          last_ready_cyc = 0;
    int          accept_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    bit          rst_zero = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: slave index 0..3 for mapped addresses, 4 for unmapped
    function automatic int unsigned slave_of(input logic [31:0] a);
        if (a[31:12] >= 20'h10000 && a[31:12] <= 20'h10003) return 32'(a[31:12] - 20'h10000);
        return 4;
    endfunction

    function automatic logic [31:0] slave_data(input int unsigned s, input logic [31:0] a);
        logic [31:0] lo;
        lo = {20'h0, a[11:0]};
        case (s)
            1: return 32'h6010_0000 | lo;
            2: return 32'hF2D0_0000 | lo;
            3: return 32'h5BA3_0000 ^ a;
            default: return model_mem.exists(32'(a[11:2])) ? model_mem[32'(a[11:2])] : 32'h0;
        endcase
    endfunction

    always @(posedge PCLK) cyc <= cyc + 1;

    // Compare process: every cycle, DUT outputs against the queued expectation
    always @(negedge PCLK) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = '{psel: 4'h0, penable: 1'b0, chk_bus: rst_zero, paddr: 32'h0, pwdata: 32'h0,
                    pwrite: 1'b0, ready: 1'b0, err: 1'b0, chk_rdata: 1'b0, rdata: 32'h0};
        end
        check("psel", {28'h0, PSEL3, PSEL2, PSEL1, PSEL0}, {28'h0, cur.psel});
        check("penable", {31'h0, PENABLE}, {31'h0, cur.penable});
        check("ready", {31'h0, ready}, {31'h0, cur.ready});
        if (cur.chk_bus) begin
            check("paddr", PADDR, cur.paddr);
            check("pwdata", PWDATA, cur.pwdata);
            check("pwrite", {31'h0, PWRITE}, {31'h0, cur.pwrite});
        end
        if (cur.ready) check("err", {31'h0, err}, {31'h0, cur.err});
        if (cur.ready && cur.chk_rdata) check("rdata", rdata, cur.rdata);
        if (ready) begin
            n_ready++;
            last_ready_cyc = cyc;
            last_rdata = rdata;
            last_err = err;
        end
    end

    // One CPU transaction; returns at the start of the following IDLE cycle
    task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d, input bit keep);
        int unsigned s;
        int unsigned n;
        exp_t        x;
        s = slave_of(a);
        x = '{psel: 4'h0, penable: 1'b0, chk_bus: 1'b0, paddr: a, pwdata: d, pwrite: wr,
              ready: 1'b0, err: 1'b0, chk_rdata: 1'b0, rdata: 32'h0};
        q.push_back(x);
        x.chk_bus = 1'b1;
        x.psel = (s < 4) ? 4'(1 << s) : 4'h0;
        if (s == 4) begin
            n = 1; x.err = 1'b1; x.chk_rdata = 1'b1; x.rdata = 32'h0;
        end else if (s == 3 && !s3_rdy) begin
            n = TO + 1; x.err = 1'b1; x.chk_rdata = 1'b1; x.rdata = 32'hDEAD_BEEF;
        end else begin
            n = (s == 0) ? 2 : 1; x.err = 1'b0; x.chk_rdata = !wr; x.rdata = slave_data(s, a);
        end
        q.push_back(x);
        x.penable = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            x.ready = (i == int'(n) - 1);
            q.push_back(x);
        end
        if (wr && s == 0) model_mem[32'(a[11:2])] = d;
        rst_zero = 1'b0;
        transfer = 1'b1; write = wr; addr = a; wdata = d;
        accept_cyc = cyc;
        @(posedge PCLK); #1;
        transfer = keep; addr = ~a; wdata = ~d; write = ~wr;
        repeat (n + 1) @(posedge PCLK);
        #1;
        if (!keep) transfer = 1'b0;
    endtask

    int   rdy_before;
    exp_t ab;

    initial begin
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;

        // Store then load to RAM
        txn(1'b1, 32'h1000_0004, 32'hCAFE_F00D, 1'b0);
        check("lat_ram_wr", 32'(last_ready_cyc - accept_cyc), 32'd3);
        check("model_ram", model_mem[1], 32'hCAFE_F00D);
        check("ram_cell", ram[1], 32'hCAFE_F00D);
        txn(1'b0, 32'h1000_0004, 32'h0, 1'b0);
        check("lat_ram_rd", 32'(last_ready_cyc - accept_cyc), 32'd3);
        check("ram_rdata", last_rdata, 32'hCAFE_F00D);
        check("ram_err", {31'h0, last_err}, 32'h0);

        // Decode sweep over the zero-wait slaves
        txn(1'b0, 32'h1000_1000, 32'h1111_1111, 1'b0);
        check("lat_s1", 32'(last_ready_cyc - accept_cyc), 32'd2);
        check("s1_rdata", last_rdata, 32'h6010_0000);
        txn(1'b0, 32'h1000_2008, 32'h2222_2222, 1'b0);
        check("s2_rdata", last_rdata, 32'hF2D0_0008);
        txn(1'b0, 32'h1000_3FFC, 32'h3333_3333, 1'b0);
        check("s3_rdata", last_rdata, 32'h4BA3_3FFC);
        txn(1'b1, 32'h1000_1004, 32'h55AA_55AA, 1'b0);

        // Unmapped address
        txn(1'b0, 32'h2000_0000, 32'h0, 1'b0);
        check("lat_unmapped", 32'(last_ready_cyc - accept_cyc), 32'd2);
        check("unmapped_err", {31'h0, last_err}, 32'h1);
        check("unmapped_rdata", last_rdata, 32'h0);

        // Timeout on a hung slave 3, then a normal RAM access
        s3_rdy = 1'b0;
        txn(1'b0, 32'h1000_3000, 32'h0, 1'b0);
        check("lat_timeout", 32'(last_ready_cyc - accept_cyc), 32'd6);
        check("timeout_rdata", last_rdata, 32'hDEAD_BEEF);
        check("timeout_err", {31'h0, last_err}, 32'h1);
        s3_rdy = 1'b1;
        txn(1'b0, 32'h1000_0004, 32'h0, 1'b0);
        check("after_to_rdata", last_rdata, 32'hCAFE_F00D);

        // Back-to-back stores with transfer held and CPU inputs changing
        txn(1'b1, 32'h1000_0010, 32'h1234_5678, 1'b1);
        txn(1'b1, 32'h1000_0014, 32'h9ABC_DEF0, 1'b0);
        check("b2b_ram4", ram[4], 32'h1234_5678);
        check("b2b_ram5", ram[5], 32'h9ABC_DEF0);
        txn(1'b0, 32'h1000_0010, 32'h0, 1'b0);
        check("b2b_rd4", last_rdata, 32'h1234_5678);

        // Reset during the ACCESS wait of a RAM read
        ab = '{psel: 4'h0, penable: 1'b0, chk_bus: 1'b0, paddr: 32'h1000_0014, pwdata: 32'h7777_8888,
               pwrite: 1'b0, ready: 1'b0, err: 1'b0, chk_rdata: 1'b0, rdata: 32'h0};
        q.push_back(ab);
        ab.psel = 4'h1; ab.chk_bus = 1'b1;
        q.push_back(ab);
        ab.penable = 1'b1;
        q.push_back(ab);
        rst_zero = 1'b0;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_0014; wdata = 32'h7777_8888;
        @(posedge PCLK); #1;
        transfer = 1'b0;
        @(posedge PCLK); #1;
        rdy_before = n_ready;
        @(negedge PCLK); #1;
        rst_zero = 1'b1;
        PRESET = 1'b1;
        #1;
        check("rst_penable", {31'h0, PENABLE}, 32'h0);
        check("rst_psel", {28'h0, PSEL3, PSEL2, PSEL1, PSEL0}, 32'h0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check("abort_no_ready", 32'(n_ready - rdy_before), 32'h0);
        txn(1'b0, 32'h1000_0014, 32'h0, 1'b0);
        check("post_rst_rdata", last_rdata, 32'h9ABC_DEF0);
        check("post_rst_lat", 32'(last_ready_cyc - accept_cyc), 32'd3);

        repeat (3) @(posedge PCLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB bridge between the RISC-V core's data-bus port and the peripheral APB bus. Accepts one CPU load/store at a time, decodes the address to one of four slaves (RAM, GPIO, FND, spare), and runs a standard two-phase APB transfer (SETUP, ACCESS with wait states). Sits directly upstream of the APB RAM, GPIO and FND slaves, and returns read data and a completion strobe to the core. Includes a wait-state timeout so a hung slave cannot stall the core forever.

## Interface
- TIMEOUT, 255: maximum ACCESS cycles without PREADY before an error completion; range 1..65535.
- PCLK  in  1  system clock; all state updates on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- transfer  in  1  CPU request; sampled only in IDLE.
- write  in  1  1 = store, 0 = load; latched with transfer.
- addr  in  32  byte address; latched with transfer.
- wdata  in  32  store data; latched with transfer.
- rdata  out  32  load data; valid only while ready=1.
- ready  out  1  one-cycle completion strobe.
- err  out  1  qualifies ready: 1 = unmapped address or timeout.
- PADDR  out  32  latched address.
- PWDATA  out  32  latched write data.
- PWRITE  out  1  latched direction.
- PENABLE  out  1  high in ACCESS only.
- PSEL0..PSEL3  out  1 each  slave selects (0 RAM, 1 GPIO, 2 FND, 3 spare).
- PRDATA0..PRDATA3  in  32 each  slave read data.
- PREADY0..PREADY3  in  1 each  slave ready.

## Operation
- Address decode on latched addr[31:12]: 0x10000 → slave 0, 0x10001 → 1, 0x10002 → 2, 0x10003 → 3; anything else unmapped. addr[11:0] is passed through unchanged on PADDR.
- FSM states:
  - IDLE: all PSEL and PENABLE low. If transfer=1, latch addr, wdata, write into PADDR, PWDATA, PWRITE; go to SETUP.
  - SETUP: PSELn high for the decoded slave only, PENABLE=0. Always go to ACCESS next. For unmapped addresses no PSEL asserts.
  - ACCESS: decoded PSELn=1, PENABLE=1. If PREADYn=1, assert ready, drive rdata=PRDATAn and err=0, then go to IDLE.
- Unmapped address in ACCESS: ready=1, err=1, rdata=0, go to IDLE. No slave is touched.
- Timeout: the wait counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY. When the count reaches TIMEOUT, ready=1, err=1, rdata=0xDEAD_BEEF, go to IDLE.
- PREADYx/PRDATAx of non-selected slaves and any PREADY outside ACCESS are ignored. Slaves may hold PREADY high one cycle after completion; this is harmless.
- transfer held high after completion starts a new transaction from IDLE. A transfer arriving in SETUP or ACCESS is ignored (CPU holds request until ready).
- CPU-side addr/wdata/write may change after the IDLE acceptance cycle without affecting the APB outputs.
- Reset (any state, including mid-ACCESS): state=IDLE, PSEL0..3=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, wait counter=0. ready, err and rdata are 0 because they are derived from state. An aborted transfer produces no ready.

## Timing
- ready, err and rdata are combinational from state, PREADYn and PRDATAn in ACCESS. All APB outputs are registered.
- Minimum transaction, zero-wait slave: transfer seen in cycle N; SETUP in N+1; ACCESS with ready in N+2; IDLE in N+3.
- APB RAM, which registers PREADY: SETUP N+1; ACCESS N+2 (no PREADY); ACCESS N+3 ready; IDLE N+4.
- Back-to-back: IDLE lasts at least one cycle between transfers, so PENABLE is guaranteed low before the next SETUP.
- Timeout completion occurs TIMEOUT cycles after ACCESS entry, e.g. ACCESS cycle index TIMEOUT+1 counting from 1 at entry.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the last ACCESS cycle.

## Test plan
- Store then load to RAM: write 0x1000_0004 ← 0xCAFE_F00D, then read 0x1000_0004. Required: PSEL0 only; each transfer completes 4 cycles after request; rdata=0xCAFE_F00D, err=0.
- Decode sweep: reads at 0x1000_1000, 0x1000_2008 and 0x1000_3FFC. Required: PSEL1, PSEL2 and PSEL3 respectively, with PADDR matching the request; zero-wait slave model completes in 3 cycles.
- Unmapped: read 0x2000_0000. Required: no PSEL for the whole transaction; ready with err=1, rdata=0 in cycle N+2.
- Timeout: TIMEOUT=4, slave 3 holds PREADY low. Required: ready with err=1, rdata=0xDEAD_BEEF on the 5th ACCESS cycle; state returns to IDLE; a follow-up RAM access succeeds.
- Back-to-back and latch: transfer held high for two stores while addr/wdata change the cycle after acceptance. Required: PADDR/PWDATA hold the accepted values; one IDLE cycle between transactions; RAM contents match the two accepted stores.
- Reset mid-ACCESS: assert PRESET during the ACCESS wait of a RAM read. Required: all APB outputs 0 asynchronously, no ready pulse, next request completes normally.
